accumulate_frame_gen: RTL and testbench
=======================================

// Module: accumulate_frame_gen
// PURPOSE
//  - Upstream framing stage for floating_point_accumulate: turns a length command plus a valid/ready element stream
//    into the validIn/startIn/lastIn/dataIn framing the accumulator expects (no backpressure on that side).
//  - One command = one vector = one accumulator result. Also exposes frame/element status counters.
// PARAMETERS
//  FRAC_WIDTH   24   fraction width incl. hidden bit; DATA_WIDTH = FRAC_WIDTH + EXP_WIDTH
//  EXP_WIDTH     8   exponent width
//  LEN_WIDTH    16   width of vector-length command field
//  CNT_WIDTH    32   width of status counters
// PORTS
//  clkIn         in   1            clock, all logic on rising edge
//  rstIn         in   1            synchronous reset, ACTIVE-LOW (0 = reset)
//  cmdValidIn    in   1            command valid
//  cmdReadyOut   out  1            command ready
//  cmdLenIn      in   LEN_WIDTH    number of elements in vector
//  elemValidIn   in   1            element valid
//  elemReadyOut  out  1            element ready
//  elemDataIn    in   DATA_WIDTH   element (FP word, passed through unmodified)
//  validOut      out  1            to accumulator validIn
//  startOut      out  1            to accumulator startIn (first element of vector)
//  lastOut       out  1            to accumulator lastIn (final element of vector)
//  dataOut       out  DATA_WIDTH   to accumulator dataIn
//  busyOut       out  1            1 whenever FSM not in IDLE
//  frameCntOut   out  CNT_WIDTH    vectors fully issued (last element sent), wraps at 2^CNT_WIDTH
//  elemCntOut    out  CNT_WIDTH    elements issued incl. injected zeros, wraps
//  errOut        out  1            one-cycle pulse on dropped zero-length command (macro off only)
// BEHAVIOUR
//  - Reset (rstIn==0 at clock edge): state=IDLE; validOut/startOut/lastOut/errOut=0; dataOut=0; counters=0.
//    Reset mid-frame abandons the partial vector silently; no lastOut is emitted for it.
//  - All outputs registered. Element accepted at edge N appears on validOut/dataOut in cycle N+1, held 1 cycle.
//  - Handshake: transfer when valid&ready at the rising edge. Ready depends only on state (no comb valid->ready path).
//  - States:
//    IDLE:   cmdReadyOut=1, elemReadyOut=0. Cmd accepted with len>0: remR=len, firstR=1 -> STREAM.
//            Cmd accepted with len==0: see CONFIGURATION.
//    STREAM: cmdReadyOut=0, elemReadyOut=1. Per accepted element: validOut=1, dataOut=elem, startOut=firstR,
//            lastOut=(remR==1); firstR<=0; remR<=remR-1; elemCnt++. When remR==1: frameCnt++, -> IDLE.
//            Element gaps (elemValidIn=0) insert bubbles: validOut=0; start/last ignored by accumulator then.
//    ZERO:   emit one word: validOut=1, dataOut=0 (+0.0), startOut=1, lastOut=1; elemCnt++, frameCnt++; -> IDLE.
//  - len==1: single element carries startOut=1 and lastOut=1 together.
//  - len==2^LEN_WIDTH-1: full count, no overflow of remR (decrement-only).
//  - Back-to-back commands: one bubble cycle (IDLE) between last element of a vector and first of the next.
//  - Data never modified: NaN/Inf/-0.0 pass through bit-exact. Counters wrap modulo 2^CNT_WIDTH, no saturation.
// CONFIGURATION
//  ACCUM_ZERO_LEN_EN defined:     len==0 command -> ZERO state, accumulator returns +0.0 for it; errOut tied 0.
//  ACCUM_ZERO_LEN_EN not defined: len==0 command accepted and dropped; errOut pulses 1 for one cycle
//                                 (cycle after acceptance); stays IDLE; no output, counters unchanged.
// STRUCTURE
//  - Shared package fp_accum_pkg: DATA_WIDTH derivation, FP_POS_ZERO constant, frame-gen state encoding
//    (IDLE/STREAM/ZERO), LEN_WIDTH/CNT_WIDTH defaults.
//  - Single module, no sub-modules; FSM, remaining counter and status counters inline.
// TESTING
//  1 len=4, elems 1.0,2.0,3.0,4.0 continuous -> 4 validOut cycles, start on 1st, last on 4th; accum result 10.0; frameCnt=1.
//  2 len=1, elem 0x40490FDB -> one output with start=last=1, dataOut=0x40490FDB; elemCnt=1.
//  3 len=3 with elemValidIn gaps of 2 cycles -> validOut only on 3 accepted cycles, start/last placement unchanged.
//  4 len=0: macro on -> one output 0x00000000 start=last=1, frameCnt=1; macro off -> errOut 1-cycle pulse, no output.
//  5 rstIn=0 after 2 of 5 elements -> outputs 0 next cycle, counters 0; new len=2 cmd afterwards frames correctly.
//  6 two cmds len=3 back-to-back, elemValidIn held 1 -> exactly one bubble between vectors; cmdReadyOut low in STREAM.

Source files
------------

// File: rtl/fp_accum_pkg.sv
// Shared definitions for the floating-point accumulate path: default widths,
// data-word width derivation, the +0.0 constant and the frame-generator states.
package fp_accum_pkg;

  localparam int FRAC_WIDTH_DEF = 24;
  localparam int EXP_WIDTH_DEF  = 8;
  localparam int LEN_WIDTH_DEF  = 16;
  localparam int CNT_WIDTH_DEF  = 32;

  // Fraction field already carries the hidden bit, so word = frac + exp.
  function automatic int data_width(input int frac_w, input int exp_w);
    return frac_w + exp_w;
  endfunction

  localparam int DATA_WIDTH_DEF = data_width(FRAC_WIDTH_DEF, EXP_WIDTH_DEF);

  // +0.0 is the all-zero word in this format.
  localparam logic [DATA_WIDTH_DEF-1:0] FP_POS_ZERO = '0;

  typedef enum logic [1:0] {
    FG_IDLE   = 2'd0,
    FG_STREAM = 2'd1,
    FG_ZERO   = 2'd2
  } fg_state_e;

endpackage

// File: rtl/accumulate_frame_gen.sv
// accumulate_frame_gen: turns a length command plus a valid/ready element
// stream into start/last/valid framing for the accumulator, with frame and
// element status counters.
// Build option ACCUM_ZERO_LEN_EN: a zero-length command emits a single +0.0
// word framed as start+last; without it the command is dropped and errOut
// pulses for one cycle.
module accumulate_frame_gen
  import fp_accum_pkg::*;
#(
  parameter int FRAC_WIDTH = FRAC_WIDTH_DEF,
  parameter int EXP_WIDTH  = EXP_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  localparam int DATA_WIDTH = data_width(FRAC_WIDTH, EXP_WIDTH)
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  cmdValidIn,
  output logic                  cmdReadyOut,
  input  logic [LEN_WIDTH-1:0]  cmdLenIn,
  input  logic                  elemValidIn,
  output logic                  elemReadyOut,
  input  logic [DATA_WIDTH-1:0] elemDataIn,
  output logic                  validOut,
  output logic                  startOut,
  output logic                  lastOut,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  busyOut,
  output logic [CNT_WIDTH-1:0]  frameCntOut,
  output logic [CNT_WIDTH-1:0]  elemCntOut,
  output logic                  errOut
);

  fg_state_e             r_state, w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_rem, w_rem_nxt;
  logic                  r_first, w_first_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_start, w_start_nxt;
  logic                  r_last, w_last_nxt;
  logic                  r_err, w_err_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic [CNT_WIDTH-1:0]  r_frame_cnt, w_frame_cnt_nxt;
  logic [CNT_WIDTH-1:0]  r_elem_cnt, w_elem_cnt_nxt;
  logic                  w_rem_is_one;

  // Ready is a pure function of state, so there is no valid->ready comb path.
  assign cmdReadyOut  = (r_state == FG_IDLE);
  assign elemReadyOut = (r_state == FG_STREAM);
  assign busyOut      = (r_state != FG_IDLE);

  assign validOut    = r_valid;
  assign startOut    = r_start;
  assign lastOut     = r_last;
  assign dataOut     = r_data;
  assign frameCntOut = r_frame_cnt;
  assign elemCntOut  = r_elem_cnt;
  assign errOut      = r_err;

  assign w_rem_is_one = (r_rem == LEN_WIDTH'(1));

  // Next-state and next-output decode; output strobes default low each cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_rem_nxt       = r_rem;
    w_first_nxt     = r_first;
    w_valid_nxt     = 1'b0;
    w_start_nxt     = 1'b0;
    w_last_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_data_nxt      = r_data;
    w_frame_cnt_nxt = r_frame_cnt;
    w_elem_cnt_nxt  = r_elem_cnt;
    case (r_state)
      FG_IDLE: begin
        if (cmdValidIn) begin
          if (cmdLenIn != '0) begin
            w_rem_nxt   = cmdLenIn;
            w_first_nxt = 1'b1;
            w_state_nxt = FG_STREAM;
          end else begin
`ifdef ACCUM_ZERO_LEN_EN
            w_state_nxt = FG_ZERO;
`else
            w_err_nxt   = 1'b1;
`endif
          end
        end
      end
      FG_STREAM: begin
        if (elemValidIn) begin
          w_valid_nxt    = 1'b1;
          w_data_nxt     = elemDataIn;
          w_start_nxt    = r_first;
          w_last_nxt     = w_rem_is_one;
          w_first_nxt    = 1'b0;
          w_rem_nxt      = r_rem - LEN_WIDTH'(1);
          w_elem_cnt_nxt = r_elem_cnt + CNT_WIDTH'(1);
          if (w_rem_is_one) begin
            w_frame_cnt_nxt = r_frame_cnt + CNT_WIDTH'(1);
            w_state_nxt     = FG_IDLE;
          end
        end
      end
      FG_ZERO: begin
        // Empty vector: hand the accumulator one +0.0 so it still yields a result.
        w_valid_nxt     = 1'b1;
        w_data_nxt      = DATA_WIDTH'(FP_POS_ZERO);
        w_start_nxt     = 1'b1;
        w_last_nxt      = 1'b1;
        w_elem_cnt_nxt  = r_elem_cnt + CNT_WIDTH'(1);
        w_frame_cnt_nxt = r_frame_cnt + CNT_WIDTH'(1);
        w_state_nxt     = FG_IDLE;
      end
      default: w_state_nxt = FG_IDLE;
    endcase
  end

  // State register; reset abandons any partial vector.
  always_ff @(posedge clkIn) begin
    if (!rstIn) r_state <= FG_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Registered outputs, remaining-count tracker and status counters.
  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      r_rem       <= '0;
      r_first     <= 1'b0;
      r_valid     <= 1'b0;
      r_start     <= 1'b0;
      r_last      <= 1'b0;
      r_err       <= 1'b0;
      r_data      <= '0;
      r_frame_cnt <= '0;
      r_elem_cnt  <= '0;
    end else begin
      r_rem       <= w_rem_nxt;
      r_first     <= w_first_nxt;
      r_valid     <= w_valid_nxt;
      r_start     <= w_start_nxt;
      r_last      <= w_last_nxt;
      r_err       <= w_err_nxt;
      r_data      <= w_data_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_elem_cnt  <= w_elem_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_accumulate_frame_gen.sv
// Self-checking bench for accumulate_frame_gen. A transaction-level model keeps
// a queue of expected output beats, each stamped with the clock edge at which
// it must appear, plus expected busy/error/counter values.
module tb_accumulate_frame_gen;

  logic        clkIn = 1'b0;
  logic        rstIn = 1'b0;
  logic        cmdValidIn = 1'b0;
  logic        cmdReadyOut;
  logic [15:0] cmdLenIn = '0;
  logic        elemValidIn = 1'b0;
  logic        elemReadyOut;
  logic [31:0] elemDataIn = '0;
  logic        validOut, startOut, lastOut, busyOut, errOut;
  logic [31:0] dataOut, frameCntOut, elemCntOut;

  accumulate_frame_gen dut (
    .clkIn(clkIn), .rstIn(rstIn),
    .cmdValidIn(cmdValidIn), .cmdReadyOut(cmdReadyOut), .cmdLenIn(cmdLenIn),
    .elemValidIn(elemValidIn), .elemReadyOut(elemReadyOut), .elemDataIn(elemDataIn),
    .validOut(validOut), .startOut(startOut), .lastOut(lastOut), .dataOut(dataOut),
    .busyOut(busyOut), .frameCntOut(frameCntOut), .elemCntOut(elemCntOut), .errOut(errOut)
  );

  always #5 clkIn = ~clkIn;

  typedef struct {
    int          due;
    logic        s;
    logic        l;
    logic [31:0] d;
  } beat_t;

  beat_t       q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          busy_on_at = -1, busy_off_at = -1, err_due = -1;
  bit          on_stream = 0, exp_busy = 0, exp_stream = 0;
  logic [31:0] exp_frame = 0, exp_elem = 0;
  int          start_cyc = -1, last_cyc = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock edge, then compare every observable against the model.
  task automatic step();
    logic  was_rst;
    beat_t b;
    was_rst = !rstIn;
    @(posedge clkIn);
    cyc++;
    #1;
    if (was_rst) begin
      q.delete();
      exp_frame = 0; exp_elem = 0;
      exp_busy = 0; exp_stream = 0;
      busy_on_at = -1; busy_off_at = -1; err_due = -1;
    end else begin
      if (cyc == busy_on_at) begin exp_busy = 1; exp_stream = on_stream; end
      if (cyc == busy_off_at) begin exp_busy = 0; exp_stream = 0; end
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      b = q.pop_front();
      exp_elem++;
      if (b.l) exp_frame++;
      if (b.s) start_cyc = cyc;
      if (b.l) last_cyc = cyc;
      chk("valid", validOut, 1);
      chk("start", startOut, b.s);
      chk("last", lastOut, b.l);
      chk("data", dataOut, b.d);
    end else begin
      chk("valid_idle", validOut, 0);
    end
    if (was_rst) begin
      chk("rst_data", dataOut, 0);
      chk("rst_start", startOut, 0);
      chk("rst_last", lastOut, 0);
    end
    chk("err", errOut, (cyc == err_due));
    chk("busy", busyOut, exp_busy);
    chk("cmd_ready", cmdReadyOut, !exp_busy);
    chk("elem_ready", elemReadyOut, exp_stream);
    chk("elem_cnt", elemCntOut, exp_elem);
    chk("frame_cnt", frameCntOut, exp_frame);
  endtask

  task automatic do_reset();
    rstIn = 0; cmdValidIn = 0; elemValidIn = 0;
    step();
    rstIn = 1;
  endtask

  task automatic issue_cmd(input int len);
    int t;
    t = 0;
    cmdValidIn = 1;
    cmdLenIn = 16'(len);
    while (cmdReadyOut !== 1'b1 && t < 50) begin step(); t++; end
    chk("cmd_ready_wait", cmdReadyOut, 1);
    if (len > 0) begin
      busy_on_at = cyc + 1; on_stream = 1;
    end else begin
`ifdef ACCUM_ZERO_LEN_EN
      busy_on_at = cyc + 1; on_stream = 0; busy_off_at = cyc + 2;
      q.push_back('{due: cyc + 2, s: 1'b1, l: 1'b1, d: 32'h0});
`else
      err_due = cyc + 1;
`endif
    end
    step();
    cmdValidIn = 0;
  endtask

  task automatic send_elem(input bit first, input bit last, input logic [31:0] data, input int gaps);
    int t;
    repeat (gaps) begin elemValidIn = 0; step(); end
    elemValidIn = 1;
    elemDataIn = data;
    t = 0;
    while (elemReadyOut !== 1'b1 && t < 50) begin step(); t++; end
    chk("elem_ready_wait", elemReadyOut, 1);
    q.push_back('{due: cyc + 1, s: first, l: last, d: data});
    if (last) busy_off_at = cyc + 1;
    step();
  endtask

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 4))
      0: return 32'h7FC00000;
      1: return 32'h7F800000;
      2: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_cmd(input int len, input int gmin, input int gmax);
    issue_cmd(len);
    for (int i = 0; i < len; i++)
      send_elem(i == 0, i == len - 1, rand_data(), $urandom_range(gmin, gmax));
  endtask

  initial begin
    int lv1;
    logic [31:0] t1d[4];
    // reset state
    step(); step();
    rstIn = 1;
    step();

    // T1: len=4, 1.0..4.0 continuous
    t1d[0] = 32'h3F800000; t1d[1] = 32'h40000000; t1d[2] = 32'h40400000; t1d[3] = 32'h40800000;
    do_reset();
    issue_cmd(4);
    for (int i = 0; i < 4; i++) send_elem(i == 0, i == 3, t1d[i], 0);
    elemValidIn = 0;
    step();
    chk("t1_frame_cnt", frameCntOut, 1);
    chk("t1_elem_cnt", elemCntOut, 4);

    // T2: len=1, start and last together
    do_reset();
    issue_cmd(1);
    send_elem(1, 1, 32'h40490FDB, 0);
    elemValidIn = 0;
    chk("t2_data", dataOut, 32'h40490FDB);
    chk("t2_elem_cnt", elemCntOut, 1);

    // T3: len=3 with 2-cycle gaps
    do_reset();
    issue_cmd(3);
    for (int i = 0; i < 3; i++) send_elem(i == 0, i == 2, rand_data(), 2);
    elemValidIn = 0;
    step(); step();

    // T4: zero-length command
    do_reset();
    issue_cmd(0);
    step(); step();
`ifdef ACCUM_ZERO_LEN_EN
    chk("t4_frame_cnt", frameCntOut, 1);
`else
    chk("t4_frame_cnt", frameCntOut, 0);
`endif

    // T5: reset after 2 of 5 elements, then a clean len=2 vector
    do_reset();
    issue_cmd(5);
    send_elem(1, 0, rand_data(), 0);
    send_elem(0, 0, rand_data(), 0);
    rstIn = 0; elemValidIn = 1; elemDataIn = 32'h12345678;
    step();
    rstIn = 1; elemValidIn = 0;
    chk("t5_frame_cnt", frameCntOut, 0);
    chk("t5_elem_cnt", elemCntOut, 0);
    chk("t5_valid", validOut, 0);
    do_cmd(2, 0, 0);
    elemValidIn = 0;
    step();

    // T6: two len=3 back-to-back, elemValidIn held high
    do_reset();
    elemValidIn = 1;
    do_cmd(3, 0, 0);
    lv1 = last_cyc;
    do_cmd(3, 0, 0);
    chk("t6_bubble", 64'(start_cyc - lv1), 2);
    elemValidIn = 0;
    step();

    // Random commands, lengths including 0 and 1, random gaps
    do_reset();
    for (int n = 0; n < 25; n++) begin
      do_cmd($urandom_range(0, 6), 0, 3);
      elemValidIn = 0;
      repeat ($urandom_range(0, 2)) step();
    end
    step(); step();

    // Maximum length vector
    do_reset();
    do_cmd(65535, 0, 0);
    elemValidIn = 0;
    step();
    chk("max_frame_cnt", frameCntOut, 1);
    chk("max_elem_cnt", elemCntOut, 65535);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
